urv_fetch: RTL and testbench

//  Instruction fetch stage of the uRV pipeline; sits directly upstream of decode/execute.

---
 rtl/urv_fetch.sv | 119 +++++++++++
 tb/tb_urv_fetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : urv_fetch
// Purpose  : uRV instruction fetch: sequential PC generation, pipelined
//            instruction-memory reads, in-order prefetch FIFO, branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module urv_fetch #(
   parameter logic [31:0] g_reset_vector    = 32'h0000_0000,
   parameter int unsigned g_fifo_depth      = 2,
   parameter int unsigned g_max_outstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic [31:0] im_addr_o,
   output logic        im_rd_o,
   input  logic [31:0] im_data_i,
   input  logic        im_valid_i,
   input  logic        x_bra_i,
   input  logic [31:0] x_pc_bra_i,
   input  logic        f_stall_i,
   output logic        f_valid_o,
   output logic [31:0] f_ir_o,
   output logic [31:0] f_pc_o
);

   localparam int unsigned c_PTR_W = (g_fifo_depth > 1) ? $clog2(g_fifo_depth) : 1;
   localparam int unsigned c_CNT_W = $clog2(g_fifo_depth + 1);
   localparam int unsigned c_INF_W = $clog2(g_max_outstanding + 1);

   logic [31:0]        r_fetch_pc;
   logic [c_INF_W-1:0] r_inflight;
   logic [c_INF_W-1:0] r_discard;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [31:0]        r_fifo_pc [g_fifo_depth];
   logic [31:0]        r_fifo_ir [g_fifo_depth];

   logic        w_empty;
   logic        w_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_issue;
   logic [31:0] w_occupancy;
   logic [31:0] w_resp_pc;

   assign w_empty     = (r_count == '0);
   assign w_valid     = !w_empty && !x_bra_i;
   assign w_pop       = w_valid && !f_stall_i;
   assign w_occupancy = 32'(r_inflight) + 32'(r_count) - 32'(w_pop);
   assign w_issue     = rst_n_i && !x_bra_i
                        && (w_occupancy < g_fifo_depth)
                        && (32'(r_inflight) < g_max_outstanding);
   assign w_push      = im_valid_i && (r_discard == '0) && !x_bra_i;

   // Kept reads are the most recent issues since the last redirect and are
   // sequential, so the oldest one still outstanding sits inflight words back.
   assign w_resp_pc   = r_fetch_pc - (32'(r_inflight) << 2);

   assign im_addr_o = r_fetch_pc;
   assign im_rd_o   = w_issue;
   assign f_valid_o = w_valid;
   assign f_ir_o    = r_fifo_ir[r_rd_ptr];
   assign f_pc_o    = r_fifo_pc[r_rd_ptr];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_fetch_pc <= g_reset_vector;
         r_inflight <= '0;
         r_discard  <= '0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         r_inflight <= r_inflight + c_INF_W'(w_issue) - c_INF_W'(im_valid_i);
         if (x_bra_i) begin
            r_fetch_pc <= x_pc_bra_i & 32'hFFFF_FFFC;
            r_discard  <= r_inflight - c_INF_W'(im_valid_i);
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
         end else begin
            if (w_issue) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (im_valid_i && (r_discard != '0)) begin
               r_discard <= r_discard - c_INF_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < int'(g_fifo_depth); i++) begin
            r_fifo_pc[i] <= '0;
            r_fifo_ir[i] <= '0;
         end
      end else if (w_push) begin
         r_fifo_pc[r_wr_ptr] <= w_resp_pc;
         r_fifo_ir[r_wr_ptr] <= im_data_i;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(w_push && !w_pop && (32'(r_count) >= g_fifo_depth)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_urv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_urv_fetch
// Purpose  : Self-checking bench for urv_fetch with an epoch-tagged fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_urv_fetch;

   localparam logic [31:0] c_RV = 32'h0000_0100;
   localparam int c_DEPTH = 2;
   localparam int c_MAXO  = 2;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [31:0] im_addr_o;
   logic        im_rd_o;
   logic [31:0] im_data_i;
   logic        im_valid_i;
   logic        x_bra_i;
   logic [31:0] x_pc_bra_i;
   logic        f_stall_i;
   logic        f_valid_o;
   logic [31:0] f_ir_o;
   logic [31:0] f_pc_o;

   urv_fetch #(
      .g_reset_vector   (c_RV),
      .g_fifo_depth     (c_DEPTH),
      .g_max_outstanding(c_MAXO)
   ) dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .im_addr_o (im_addr_o),
      .im_rd_o   (im_rd_o),
      .im_data_i (im_data_i),
      .im_valid_i(im_valid_i),
      .x_bra_i   (x_bra_i),
      .x_pc_bra_i(x_pc_bra_i),
      .f_stall_i (f_stall_i),
      .f_valid_o (f_valid_o),
      .f_ir_o    (f_ir_o),
      .f_pc_o    (f_pc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] pc;
      int          due;
      int          ep;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
   } fent_t;

   mreq_t       mem_q[$];
   fent_t       model_q[$];
   int          cyc = 0;
   int          lat = 1;
   int          epoch = 0;
   logic [31:0] issue_pc_m = c_RV;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory: fixed latency, in-order responses
   initial begin
      im_valid_i = 1'b0;
      im_data_i  = '0;
      forever begin
         @(posedge clk_i);
         cyc++;
         #1;
         if (rst_n_i === 1'b1 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            im_valid_i = 1'b1;
            im_data_i  = memfn(mem_q[0].addr);
         end else begin
            im_valid_i = 1'b0;
            im_data_i  = '0;
         end
      end
   end

   // Model: reads issued before the latest redirect carry an old epoch and are lost
   mreq_t e;
   fent_t f;
   logic  pop_m, exp_valid, exp_rd;
   int    occ;
   always @(negedge clk_i) begin
      if (rst_n_i !== 1'b1) begin
         chk("rst_im_rd", {31'b0, im_rd_o}, 32'd0);
         chk("rst_f_valid", {31'b0, f_valid_o}, 32'd0);
         chk("rst_f_pc", f_pc_o, 32'd0);
         chk("rst_f_ir", f_ir_o, 32'd0);
         model_q.delete();
         mem_q.delete();
         issue_pc_m = c_RV;
         epoch = 0;
      end else begin
         exp_valid = (model_q.size() > 0) && !x_bra_i;
         pop_m     = exp_valid && !f_stall_i;
         occ       = mem_q.size() + model_q.size() - (pop_m ? 1 : 0);
         exp_rd    = !x_bra_i && (occ < c_DEPTH) && (mem_q.size() < c_MAXO);
         chk("f_valid", {31'b0, f_valid_o}, {31'b0, exp_valid});
         if (exp_valid && f_valid_o) begin
            chk("f_pc", f_pc_o, model_q[0].pc);
            chk("f_ir", f_ir_o, model_q[0].ir);
         end
         chk("im_rd", {31'b0, im_rd_o}, {31'b0, exp_rd});
         if (exp_rd && im_rd_o) chk("im_addr", im_addr_o, issue_pc_m);
         if (pop_m) void'(model_q.pop_front());
         if (im_valid_i && mem_q.size() > 0) begin
            e = mem_q.pop_front();
            if (!x_bra_i && e.ep == epoch) begin
               f.pc = e.pc;
               f.ir = memfn(e.pc);
               model_q.push_back(f);
            end
         end
         if (x_bra_i) begin
            model_q.delete();
            epoch++;
            issue_pc_m = x_pc_bra_i & 32'hFFFF_FFFC;
         end else if (im_rd_o) begin
            e.addr = im_addr_o;
            e.pc   = issue_pc_m;
            e.due  = cyc + lat;
            e.ep   = epoch;
            mem_q.push_back(e);
            issue_pc_m = issue_pc_m + 32'd4;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic redirect(input logic [31:0] tgt, input logic stall);
      x_bra_i    = 1'b1;
      x_pc_bra_i = tgt;
      f_stall_i  = stall;
      @(posedge clk_i);
      #2;
      x_bra_i   = 1'b0;
      f_stall_i = 1'b0;
   endtask

   int          pops;
   int          n_addr;
   logic        seen_rd, got;
   logic [31:0] addrs [3];

   initial begin
      rst_n_i    = 1'b0;
      x_bra_i    = 1'b0;
      x_pc_bra_i = '0;
      f_stall_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;

      // 1: reset vector, first-word latency, one instruction per cycle
      @(negedge clk_i);
      chk("t1_rd0", {31'b0, im_rd_o}, 32'd1);
      chk("t1_addr0", im_addr_o, 32'h100);
      chk("t1_valid_c0", {31'b0, f_valid_o}, 32'd0);
      @(negedge clk_i);
      chk("t1_addr1", im_addr_o, 32'h104);
      chk("t1_valid_c1", {31'b0, f_valid_o}, 32'd0);
      @(negedge clk_i);
      chk("t1_addr2", im_addr_o, 32'h108);
      chk("t1_valid_c2", {31'b0, f_valid_o}, 32'd1);
      chk("t1_pc_c2", f_pc_o, 32'h100);
      pops = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (f_valid_o && !f_stall_i) pops++;
      end
      chk("t1_throughput", pops, 32'd10);

      // 2: five-cycle stall holds head at 0x12C
      @(posedge clk_i);
      #1;
      f_stall_i = 1'b1;
      @(negedge clk_i);
      chk("t2_pc_hold0", f_pc_o, 32'h12C);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t2_rd_off", {31'b0, im_rd_o}, 32'd0);
      chk("t2_pc_hold2", f_pc_o, 32'h12C);
      repeat (3) @(posedge clk_i);
      #1;
      f_stall_i = 1'b0;
      @(negedge clk_i);
      chk("t2_pc_release", f_pc_o, 32'h12C);
      @(negedge clk_i);
      chk("t2_pc_next", f_pc_o, 32'h130);

      // 3: 3-cycle memory, redirect to 0x203 with two reads in flight
      @(posedge clk_i);
      #2;
      lat = 3;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk_i);
         #2;
         if (mem_q.size() == 2 && !im_valid_i) begin
            got = 1'b1;
            break;
         end
      end
      chk("t3_two_inflight", {31'b0, got}, 32'd1);
      redirect(32'h0000_0203, 1'b0);
      seen_rd = 1'b0;
      got     = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk_i);
         if (im_rd_o && !seen_rd) begin
            seen_rd = 1'b1;
            chk("t3_restart_addr", im_addr_o, 32'h200);
         end
         if (f_valid_o) begin
            got = 1'b1;
            chk("t3_first_pc", f_pc_o, 32'h200);
            chk("t3_first_ir", f_ir_o, memfn(32'h200));
            break;
         end
      end
      chk("t3_timeout", {30'b0, seen_rd, got}, 32'd3);

      // 4: redirect coinciding with a response (and with stall)
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk_i);
         #2;
         if (im_valid_i && mem_q.size() >= 2) begin
            got = 1'b1;
            break;
         end
      end
      chk("t4_resp_with_inflight", {31'b0, got}, 32'd1);
      redirect(32'h0000_0400, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk_i);
         if (f_valid_o) begin
            got = 1'b1;
            chk("t4_first_pc", f_pc_o, 32'h400);
            break;
         end
      end
      chk("t4_timeout", {31'b0, got}, 32'd1);

      // 5: address wrap at the top of memory
      @(posedge clk_i);
      #2;
      lat = 1;
      redirect(32'hFFFF_FFF8, 1'b0);
      n_addr = 0;
      for (int k = 0; k < 30 && n_addr < 3; k++) begin
         @(negedge clk_i);
         if (im_rd_o) begin
            addrs[n_addr] = im_addr_o;
            n_addr++;
         end
      end
      chk("t5_count", n_addr, 32'd3);
      chk("t5_addr0", addrs[0], 32'hFFFF_FFF8);
      chk("t5_addr1", addrs[1], 32'hFFFF_FFFC);
      chk("t5_addr_wrap", addrs[2], 32'h0000_0000);

      // 6: asynchronous reset with a full FIFO
      @(posedge clk_i);
      #2;
      f_stall_i = 1'b1;
      repeat (4) @(negedge clk_i);
      chk("t6_full_valid", {31'b0, f_valid_o}, 32'd1);
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("t6_async_rd", {31'b0, im_rd_o}, 32'd0);
      chk("t6_async_valid", {31'b0, f_valid_o}, 32'd0);
      f_stall_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("t6_restart_rd", {31'b0, im_rd_o}, 32'd1);
      chk("t6_restart_addr", im_addr_o, c_RV);
      repeat (8) @(negedge clk_i);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
